// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing the Altera SPI core register port between two
// byte-transfer requesters; each grant runs SS write, TRDY poll, TX write, RRDY poll, RX read.
module spi_bus_arbiter #(
    parameter int unsigned POLL_LIMIT = 1023,
    parameter int unsigned SSW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rq0_valid,
    input  logic            rq1_valid,
    input  logic [7:0]      rq0_tx,
    input  logic [7:0]      rq1_tx,
    input  logic [SSW-1:0]  rq0_ss,
    input  logic [SSW-1:0]  rq1_ss,
    output logic            rq0_ack,
    output logic            rq1_ack,
    output logic            rq0_done,
    output logic            rq1_done,
    output logic [7:0]      rq0_rx,
    output logic [7:0]      rq1_rx,
    output logic            rq0_err,
    output logic            rq1_err,
    output logic [2:0]      spi_address,
    output logic            spi_chipselect,
    output logic            spi_read_n,
    output logic            spi_write_n,
    output logic [15:0]     spi_writedata,
    input  logic [15:0]     spi_readdata
);

    localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

    localparam logic [2:0] A_RXDATA = 3'd0;
    localparam logic [2:0] A_TXDATA = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_SSEL   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_GRANT, S_WR_SS, S_RD_ST_T, S_CHK_T, S_WR_TX,
        S_RD_ST_R, S_CHK_R, S_RD_RX, S_CAP_RX, S_DONE, S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic [7:0]       tx_q, tx_d;
    logic [SSW-1:0]   ss_q, ss_d;
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]       rxb_q, rxb_d;
    logic             errf_q, errf_d;

    logic [1:0]       ack_q, ack_d;
    logic [1:0]       done_q, done_d;
    logic [7:0]       rx0_q, rx0_d, rx1_q, rx1_d;
    logic [1:0]       err_q, err_d;
    logic [2:0]       addr_q, addr_d;
    logic             cs_q, cs_d;
    logic             rdn_q, rdn_d;
    logic             wrn_q, wrn_d;
    logic [15:0]      wdata_q, wdata_d;

    logic             win_c;
    logic             poll_last_c;
    logic             unused_rd_hi;

    assign unused_rd_hi = ^spi_readdata[15:8];

    // Only one requester valid wins outright; on a tie the one not granted last wins.
    assign win_c       = (rq0_valid && rq1_valid) ? ~last_grant_q : rq1_valid;
    assign poll_last_c = (poll_cnt_q == CNT_W'(POLL_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        tx_d         = tx_q;
        ss_d         = ss_q;
        last_grant_d = last_grant_q;
        poll_cnt_d   = poll_cnt_q;
        rxb_d        = rxb_q;
        errf_d       = errf_q;
        unique case (state_q)
            S_IDLE: begin
                if (rq0_valid || rq1_valid) begin
                    state_d = S_GRANT;
                    id_d    = win_c;
                    tx_d    = win_c ? rq1_tx : rq0_tx;
                    ss_d    = win_c ? rq1_ss : rq0_ss;
                end
            end
            S_GRANT: begin
                state_d      = S_WR_SS;
                last_grant_d = id_q;
                errf_d       = 1'b0;
            end
            S_WR_SS: begin
                state_d    = S_RD_ST_T;
                poll_cnt_d = '0;
            end
            S_RD_ST_T: state_d = S_CHK_T;
            S_CHK_T: begin
                if (spi_readdata[6])  state_d = S_WR_TX;
                else if (poll_last_c) state_d = S_ERR;
                else begin
                    state_d    = S_RD_ST_T;
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
                end
            end
            S_WR_TX: begin
                state_d    = S_RD_ST_R;
                poll_cnt_d = '0;
            end
            S_RD_ST_R: state_d = S_CHK_R;
            S_CHK_R: begin
                if (spi_readdata[7])  state_d = S_RD_RX;
                else if (poll_last_c) state_d = S_ERR;
                else begin
                    state_d    = S_RD_ST_R;
                    poll_cnt_d = poll_cnt_q + CNT_W'(1);
                end
            end
            S_RD_RX: state_d = S_CAP_RX;
            S_CAP_RX: begin
                state_d = S_DONE;
                rxb_d   = spi_readdata[7:0];
            end
            S_ERR: begin
                state_d = S_DONE;
                rxb_d   = 8'hFF;
                errf_d  = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobes line up with the state.
    always_comb begin
        ack_d   = 2'b00;
        done_d  = 2'b00;
        rx0_d   = rx0_q;
        rx1_d   = rx1_q;
        err_d   = err_q;
        addr_d  = 3'd0;
        cs_d    = 1'b0;
        rdn_d   = 1'b1;
        wrn_d   = 1'b1;
        wdata_d = 16'h0000;
        unique case (state_d)
            S_GRANT: ack_d = {id_d, ~id_d};
            S_WR_SS: begin
                cs_d = 1'b1; wrn_d = 1'b0; addr_d = A_SSEL; wdata_d = 16'(ss_q);
            end
            S_WR_TX: begin
                cs_d = 1'b1; wrn_d = 1'b0; addr_d = A_TXDATA; wdata_d = {8'h00, tx_q};
            end
            S_RD_ST_T, S_RD_ST_R: begin
                cs_d = 1'b1; rdn_d = 1'b0; addr_d = A_STATUS;
            end
            S_RD_RX: begin
                cs_d = 1'b1; rdn_d = 1'b0; addr_d = A_RXDATA;
            end
            S_DONE: begin
                done_d = {id_q, ~id_q};
                if (id_q) begin rx1_d = rxb_d; err_d[1] = errf_d; end
                else      begin rx0_d = rxb_d; err_d[0] = errf_d; end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            tx_q         <= 8'h00;
            ss_q         <= '0;
            poll_cnt_q   <= '0;
            rxb_q        <= 8'h00;
            errf_q       <= 1'b0;
            ack_q        <= 2'b00;
            done_q       <= 2'b00;
            rx0_q        <= 8'h00;
            rx1_q        <= 8'h00;
            err_q        <= 2'b00;
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            rdn_q        <= 1'b1;
            wrn_q        <= 1'b1;
            wdata_q      <= 16'h0000;
        end else begin
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            tx_q         <= tx_d;
            ss_q         <= ss_d;
            poll_cnt_q   <= poll_cnt_d;
            rxb_q        <= rxb_d;
            errf_q       <= errf_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            rx0_q        <= rx0_d;
            rx1_q        <= rx1_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            rdn_q        <= rdn_d;
            wrn_q        <= wrn_d;
            wdata_q      <= wdata_d;
        end
    end

    assign rq0_ack        = ack_q[0];
    assign rq1_ack        = ack_q[1];
    assign rq0_done       = done_q[0];
    assign rq1_done       = done_q[1];
    assign rq0_rx         = rx0_q;
    assign rq1_rx         = rx1_q;
    assign rq0_err        = err_q[0];
    assign rq1_err        = err_q[1];
    assign spi_address    = addr_q;
    assign spi_chipselect = cs_q;
    assign spi_read_n     = rdn_q;
    assign spi_write_n    = wrn_q;
    assign spi_writedata  = wdata_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a small SPI-core register model;
// cycle k of a transfer is observed on the k-th falling edge after valid is raised.
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq0_valid = 1'b0, rq1_valid = 1'b0;
    logic [7:0]  rq0_tx = 8'h00, rq1_tx = 8'h00;
    logic [7:0]  rq0_ss = 8'h00, rq1_ss = 8'h00;
    logic        rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_err, rq1_err;
    logic [7:0]  rq0_rx, rq1_rx;
    logic [2:0]  spi_address;
    logic        spi_chipselect, spi_read_n, spi_write_n;
    logic [15:0] spi_writedata;
    logic [15:0] spi_readdata = 16'h0000;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.POLL_LIMIT(4), .SSW(8)) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
        .rq0_tx(rq0_tx), .rq1_tx(rq1_tx),
        .rq0_ss(rq0_ss), .rq1_ss(rq1_ss),
        .rq0_ack(rq0_ack), .rq1_ack(rq1_ack),
        .rq0_done(rq0_done), .rq1_done(rq1_done),
        .rq0_rx(rq0_rx), .rq1_rx(rq1_rx),
        .rq0_err(rq0_err), .rq1_err(rq1_err),
        .spi_address(spi_address), .spi_chipselect(spi_chipselect),
        .spi_read_n(spi_read_n), .spi_write_n(spi_write_n),
        .spi_writedata(spi_writedata), .spi_readdata(spi_readdata)
    );

    // SPI core model: TRDY withheld for t_fail_cfg polls, RRDY optionally never set.
    int          t_fail_cfg = 0;
    bit          rrdy_block = 1'b0;
    logic [7:0]  rx_cfg = 8'h00;
    int          t_polls = 0, r_reads = 0, rx_reads = 0, wr_n = 0;
    bit          r_phase = 1'b0;
    logic [2:0]  wr_addr_log [64];
    logic [15:0] wr_data_log [64];

    always @(posedge clk) begin
        if (spi_chipselect && !spi_write_n) begin
            if (wr_n < 64) begin
                wr_addr_log[wr_n] <= spi_address;
                wr_data_log[wr_n] <= spi_writedata;
            end
            wr_n <= wr_n + 1;
            if (spi_address == 3'd5) begin t_polls <= 0; r_phase <= 1'b0; end
            if (spi_address == 3'd1) r_phase <= 1'b1;
        end
        if (spi_chipselect && !spi_read_n) begin
            case (spi_address)
                3'd2: begin
                    if (!r_phase) begin
                        spi_readdata <= (t_polls < t_fail_cfg) ? 16'h0000 : 16'h00C0;
                        t_polls <= t_polls + 1;
                    end else begin
                        spi_readdata <= rrdy_block ? 16'h0040 : 16'h00C0;
                        r_reads <= r_reads + 1;
                    end
                end
                3'd0: begin
                    spi_readdata <= {8'h00, rx_cfg};
                    rx_reads <= rx_reads + 1;
                end
                default: spi_readdata <= 16'h0000;
            endcase
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int ack_cyc[8], ack_who[8], done_cyc[8], done_who[8];
    int n_ack, n_done;

    // Step falling edges logging ack/done events; drops both valids at the drop_at-th ack.
    task automatic watch(input string tag, input int drop_at, input int ndone, input int pulse1_at, input int maxc);
        n_ack = 0;
        n_done = 0;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (rq0_ack || rq1_ack) begin
                if (n_ack < 8) begin ack_cyc[n_ack] = k; ack_who[n_ack] = rq1_ack ? 1 : 0; end
                n_ack++;
                if (n_ack == drop_at) begin rq0_valid = 1'b0; rq1_valid = 1'b0; end
            end
            if (rq0_done || rq1_done) begin
                if (n_done < 8) begin done_cyc[n_done] = k; done_who[n_done] = rq1_done ? 1 : 0; end
                n_done++;
            end
            if (k == pulse1_at) rq1_valid = 1'b1;
            else if (k == pulse1_at + 1) rq1_valid = 1'b0;
            if (n_done >= ndone) break;
        end
        check({tag, "_done_count"}, 32'(n_done), 32'(ndone));
    endtask

    int w0, r0, x0, stray;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ack",  {rq1_ack, rq0_ack}, 32'h0);
        check("rst_done", {rq1_done, rq0_done}, 32'h0);
        check("rst_err",  {rq1_err, rq0_err}, 32'h0);
        check("rst_rx",   {rq1_rx, rq0_rx}, 32'h0);
        check("rst_bus",  {spi_chipselect, spi_read_n, spi_write_n, spi_address, spi_writedata},
              {1'b0, 1'b1, 1'b1, 3'd0, 16'h0000});
        rst = 1'b0;

        // Tie held for four transfers: alternating grants, 11 cycles apart
        rx_cfg = 8'h5C;
        rq0_tx = 8'h10; rq0_ss = 8'h01; rq1_tx = 8'h20; rq1_ss = 8'h02;
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        watch("tie", 4, 4, -1, 300);
        check("tie_ack0_cyc", 32'(ack_cyc[0]), 32'd1);
        check("tie_done0_cyc", 32'(done_cyc[0]), 32'd10);
        check("tie_order", {8'(ack_who[0]), 8'(ack_who[1]), 8'(ack_who[2]), 8'(ack_who[3])}, 32'h00010001);
        check("tie_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd11);
        check("tie_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd11);
        check("tie_gap3", 32'(ack_cyc[3] - ack_cyc[2]), 32'd11);
        check("tie_rx", {rq1_rx, rq0_rx}, 32'h5C5C);
        @(negedge clk);

        // Single transfer, both polls succeed first time
        rx_cfg = 8'hA5; w0 = wr_n;
        rq0_tx = 8'h3C; rq0_ss = 8'h01; rq0_valid = 1'b1;
        watch("single", 1, 1, -1, 100);
        check("single_ack_cyc", 32'(ack_cyc[0]), 32'd1);
        check("single_ack_who", 32'(ack_who[0]), 32'd0);
        check("single_done_cyc", 32'(done_cyc[0]), 32'd10);
        check("single_done_who", 32'(done_who[0]), 32'd0);
        check("single_rx", 32'(rq0_rx), 32'hA5);
        check("single_err", 32'(rq0_err), 32'd0);
        check("single_nwr", 32'(wr_n - w0), 32'd2);
        check("single_wr0", {wr_addr_log[w0], wr_data_log[w0]}, {3'd5, 16'h0001});
        check("single_wr1", {wr_addr_log[w0+1], wr_data_log[w0+1]}, {3'd1, 16'h003C});
        @(negedge clk);

        // Slow core: TRDY low for three polls
        t_fail_cfg = 3; rx_cfg = 8'h77;
        rq1_tx = 8'h5A; rq1_ss = 8'h02; rq1_valid = 1'b1;
        watch("slow", 1, 1, -1, 100);
        check("slow_done_cyc", 32'(done_cyc[0]), 32'd16);
        check("slow_done_who", 32'(done_who[0]), 32'd1);
        check("slow_rx", 32'(rq1_rx), 32'h77);
        check("slow_err", 32'(rq1_err), 32'd0);
        check("slow_rq0_held", 32'(rq0_rx), 32'hA5);
        t_fail_cfg = 0;
        @(negedge clk);

        // Timeout: RRDY never set with a poll limit of 4
        rrdy_block = 1'b1; r0 = r_reads; x0 = rx_reads;
        rq0_tx = 8'h0F; rq0_ss = 8'h01; rq0_valid = 1'b1;
        watch("tmo", 1, 1, -1, 100);
        check("tmo_done_cyc", 32'(done_cyc[0]), 32'd15);
        check("tmo_rx", 32'(rq0_rx), 32'hFF);
        check("tmo_err", 32'(rq0_err), 32'd1);
        check("tmo_status_reads", 32'(r_reads - r0), 32'd4);
        check("tmo_rx_reads", 32'(rx_reads - x0), 32'd0);
        check("tmo_rq1_held", {rq1_rx, 7'd0, rq1_err}, 32'h7700);
        rrdy_block = 1'b0;
        @(negedge clk);

        // Reset asserted while the TX write strobe is on the bus
        rq0_tx = 8'h11; rq0_ss = 8'h04; rq0_valid = 1'b1;
        @(negedge clk);
        rq0_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_wr", {spi_chipselect, spi_write_n, spi_address}, {1'b1, 1'b0, 3'd1});
        rst = 1'b1;
        #1;
        check("rst_mid_bus", {spi_chipselect, spi_write_n, spi_read_n}, {1'b0, 1'b1, 1'b1});
        check("rst_mid_done", {rq1_done, rq0_done}, 32'h0);
        check("rst_mid_rx", 32'(rq0_rx), 32'h00);
        check("rst_mid_err", 32'(rq0_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rx_cfg = 8'h42;
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        watch("post_rst", 1, 1, -1, 100);
        check("post_rst_winner", 32'(ack_who[0]), 32'd0);
        check("post_rst_ack_cyc", 32'(ack_cyc[0]), 32'd1);
        check("post_rst_done", {8'(done_who[0]), 8'(done_cyc[0])}, {8'd0, 8'd10});
        @(negedge clk);

        // rq1 pulses valid for one cycle while rq0 is being served
        rq0_tx = 8'h22; rq0_ss = 8'h01; rq0_valid = 1'b1;
        watch("wdraw", 1, 1, 3, 100);
        check("wdraw_acks", 32'(n_ack), 32'd1);
        check("wdraw_ack_who", 32'(ack_who[0]), 32'd0);
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rq0_ack || rq1_ack || rq0_done || rq1_done || spi_chipselect) stray++;
        end
        check("wdraw_idle_quiet", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
